// File: rtl/slowmpy_arbiter_pkg.sv
// Shared definitions for the slowmpy arbiter: FSM state encoding,
// default operand widths and requester count, and an index wrap helper.
package slowmpy_pkg;

   localparam int SLOWMPY_NA     = 18;
   localparam int SLOWMPY_NB     = 18;
   localparam int SLOWMPY_NREQ   = 4;
   localparam int SLOWMPY_LGNREQ = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2
   } state_t;

   // idx+1, wrapping to 0 past the last valid requester (n need not be a power of two)
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/slowmpy_arbiter_if.sv
// Bundle of the requester-side and multiplier-side signals of the arbiter.
// slave: the arbiter's view; master: the clients plus the multiplier.
interface slowmpy_arbiter_if
   import slowmpy_pkg::*;
#(
   parameter int NREQ   = SLOWMPY_NREQ,
   parameter int LGNREQ = SLOWMPY_LGNREQ,
   parameter int NA     = SLOWMPY_NA,
   parameter int NB     = SLOWMPY_NB
);
   logic [NREQ-1:0]    i_req;
   logic [NREQ*NA-1:0] i_req_a;
   logic [NREQ*NB-1:0] i_req_b;
   logic [NREQ-1:0]    o_ack;
   logic               o_valid;
   logic [LGNREQ-1:0]  o_id;
   logic [NA+NB-1:0]   o_p;
   logic               o_mpy_stb;
   logic [NA-1:0]      o_mpy_a;
   logic [NB-1:0]      o_mpy_b;
   logic               i_mpy_busy;
   logic               i_mpy_done;
   logic [NA+NB-1:0]   i_mpy_p;

   modport slave (
      input  i_req, i_req_a, i_req_b, i_mpy_busy, i_mpy_done, i_mpy_p,
      output o_ack, o_valid, o_id, o_p, o_mpy_stb, o_mpy_a, o_mpy_b
   );

   modport master (
      output i_req, i_req_a, i_req_b, i_mpy_busy, i_mpy_done, i_mpy_p,
      input  o_ack, o_valid, o_id, o_p, o_mpy_stb, o_mpy_a, o_mpy_b
   );
endinterface

// File: rtl/slowmpy_arbiter_rr_pick.sv
// Combinational winner search: scans the request vector starting at
// 'start' and wrapping at NREQ-1; the first asserted request wins.
module slowmpy_rr_pick
   import slowmpy_pkg::*;
#(
   parameter int NREQ   = SLOWMPY_NREQ,
   parameter int LGNREQ = SLOWMPY_LGNREQ
) (
   input  logic [NREQ-1:0]   req,
   input  logic [LGNREQ-1:0] start,
   output logic [LGNREQ-1:0] win,
   output logic              found
);
   logic [LGNREQ-1:0] cand [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [LGNREQ:0] sum;
         // index visited at search offset gi, kept below NREQ
         assign sum = {1'b0, start} + (LGNREQ+1)'(gi);
         assign cand[gi] = (sum >= (LGNREQ+1)'(NREQ)) ? LGNREQ'(sum - (LGNREQ+1)'(NREQ))
                                                       : LGNREQ'(sum);
      end
   endgenerate

   // scan from the far end so the smallest offset is the last (winning) assignment
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            win   = cand[k];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/slowmpy_arbiter.sv
// slowmpy_arbiter: shares one serial multiplier among NREQ requesters.
// IDLE picks a winner and issues its operands, ISSUE holds the start strobe
// and ack for one cycle, RUN waits for the product and returns it tagged.
// Build option SLOWMPY_ARB_RR_EN: round-robin when defined, fixed priority
// (lowest index wins) otherwise.
module slowmpy_arbiter
   import slowmpy_pkg::*;
#(
   parameter int NREQ   = SLOWMPY_NREQ,
   parameter int LGNREQ = SLOWMPY_LGNREQ,
   parameter int NA     = SLOWMPY_NA,
   parameter int NB     = SLOWMPY_NB
) (
   input logic            i_clk,
   input logic            i_reset,
   slowmpy_arbiter_if.slave bus
);
   state_t            state, state_next;
   logic [LGNREQ-1:0] owner, owner_next;
   logic [NREQ-1:0]   ack, ack_next;
   logic              valid, valid_next;
   logic [LGNREQ-1:0] id, id_next;
   logic [NA+NB-1:0]  p, p_next;
   logic              stb, stb_next;
   logic [NA-1:0]     mpy_a, mpy_a_next;
   logic [NB-1:0]     mpy_b, mpy_b_next;

   logic [LGNREQ-1:0] start;
   logic [LGNREQ-1:0] win;
   logic              found;

`ifdef SLOWMPY_ARB_RR_EN
   logic [LGNREQ-1:0] rr_ptr, rr_next;
   assign start = rr_ptr;

   // round-robin pointer register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) rr_ptr <= '0;
      else         rr_ptr <= rr_next;
   end
`else
   assign start = '0;
`endif

   slowmpy_rr_pick #(
      .NREQ   (NREQ),
      .LGNREQ (LGNREQ)
   ) u_pick (
      .req   (bus.i_req),
      .start (start),
      .win   (win),
      .found (found)
   );

   // next-state and next-output logic; strobes default low so they last one cycle
   always_comb begin
      state_next = state;
      owner_next = owner;
      ack_next   = '0;
      valid_next = 1'b0;
      stb_next   = 1'b0;
      id_next    = id;
      p_next     = p;
      mpy_a_next = mpy_a;
      mpy_b_next = mpy_b;
`ifdef SLOWMPY_ARB_RR_EN
      rr_next    = rr_ptr;
`endif
      case (state)
         IDLE: begin
            // a busy multiplier (e.g. not reset together with us) blocks new issues
            if (found && !bus.i_mpy_busy) begin
               mpy_a_next = bus.i_req_a[win*NA +: NA];
               mpy_b_next = bus.i_req_b[win*NB +: NB];
               owner_next = win;
               stb_next   = 1'b1;
               ack_next   = {{(NREQ-1){1'b0}}, 1'b1} << win;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
`ifdef SLOWMPY_ARB_RR_EN
            rr_next = LGNREQ'(wrap_inc(int'(owner), NREQ));
`endif
            state_next = RUN;
         end
         RUN: begin
            // busy is already high in the first RUN cycle, masking any stale done level
            if (bus.i_mpy_done && !bus.i_mpy_busy) begin
               p_next     = bus.i_mpy_p;
               id_next    = owner;
               valid_next = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         owner <= '0;
         ack   <= '0;
         valid <= 1'b0;
         id    <= '0;
         p     <= '0;
         stb   <= 1'b0;
         mpy_a <= '0;
         mpy_b <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         ack   <= ack_next;
         valid <= valid_next;
         id    <= id_next;
         p     <= p_next;
         stb   <= stb_next;
         mpy_a <= mpy_a_next;
         mpy_b <= mpy_b_next;
      end
   end

   assign bus.o_ack     = ack;
   assign bus.o_valid   = valid;
   assign bus.o_id      = id;
   assign bus.o_p       = p;
   assign bus.o_mpy_stb = stb;
   assign bus.o_mpy_a   = mpy_a;
   assign bus.o_mpy_b   = mpy_b;
endmodule
